i2c_master: RTL
===============

Name: i2c_master

Overview:
- Single-byte serial master that drives the team's `slave` block. It generates the serial clock, presents start, address, R/W and write data on the outbound data line, and samples ACKs and read data from the slave's separate return line.
- Sits between a host-side request interface (start/rw/addr/wdata) and the slave's `i_sclk`/`i_sdata`/`o_sdata` pins.
- One transaction is a fixed 20-bit frame matched bit-for-bit to the slave's timing.

Parameters:
- CLK_DIV, 4: i_clk cycles per serial-clock half period; legal range 1..255.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request pulse; accepted only while o_busy=0
- i_rw  input  1  1 = read (slave sends a byte), 0 = write
- i_addr  input  7  target address, sent MSB first
- i_wdata  input  8  write byte, sent MSB first
- o_busy  output  1  high from acceptance through the o_done cycle
- o_done  output  1  one-cycle completion pulse
- o_rdata  output  8  read byte; valid at o_done when i_rw=1
- o_nack  output  1  address NACK flag; valid at o_done, held until next accept
- o_data_nack  output  1  write-data NACK flag; valid at o_done, held until next accept
- o_sclk  output  1  serial clock to the slave's i_sclk
- o_sdata  output  1  serial data to the slave's i_sdata
- i_sdata  input  1  return data from the slave's o_sdata

Behaviour:
- Reset (async, i_rst_n=0) values:
  - o_sclk=0, o_sdata=1, o_busy=0, o_done=0, o_rdata=0, o_nack=0, o_data_nack=0.
  - State S_IDLE; divider and bit counters cleared.
- Reset mid-frame:
  - Frame abandoned immediately; no o_done pulse.
  - The slave is not reset; host must issue a dummy frame or reset the slave.
- States: S_IDLE, S_LOW, S_HIGH, S_DONE.
- Bit index k runs 0..19; each bit lasts 2*CLK_DIV i_clk cycles:
  - S_LOW: CLK_DIV cycles with o_sclk=0.
  - S_HIGH: CLK_DIV cycles with o_sclk=1.
- S_IDLE, on i_start=1:
  - Latch i_rw, i_addr and i_wdata.
  - Clear o_nack and o_data_nack.
  - Set k=0 and o_busy=1, then enter S_LOW.
  - i_start while o_busy=1 is ignored; no queuing.
- o_sdata changes only on the i_clk edge that enters S_LOW, so it is stable for a full half period before the o_sclk rise. Value per bit:
  - k0: 0 (start)
  - k1..k7: addr[6]..addr[0]
  - k8: rw
  - k9: 1
  - k10..k17: write = wdata[7]..wdata[0]; read = 1
  - k18, k19: 1
- i_sdata is captured on the same i_clk edge that raises o_sclk, so the value is the one from before the slave's update.
- Captures per bit:
  - k10: ack. If 1, set o_nack.
  - Read, k11..k18: o_rdata[7]..o_rdata[0].
  - Write, k19: data ack. If 1, set o_data_nack.
- Address NACK (o_nack set at k10):
  - o_sdata is forced to 1 for k11..k19 and o_rdata is not updated.
  - The frame still runs all 20 bits, so a slave that misread k10 as a start returns to idle by k19.
- End of frame: S_HIGH of k19 expires -> S_DONE.
  - S_DONE lasts one cycle with o_sclk=0, o_sdata=1, o_done=1, o_busy=1.
  - Then S_IDLE with o_busy=0.
  - i_start in the S_DONE cycle is ignored.
- Latency: o_done is asserted exactly 40*CLK_DIV i_clk cycles after the accepting edge.
- Idle bus: o_sclk=0 and o_sdata=1; o_sclk never toggles outside a frame.
- Counters:
  - Divider width is 8 bits and wraps at CLK_DIV-1.
  - k width is 5 bits and never exceeds 19.

Test Plan:
1. CLK_DIV=2, slave ADDRESS=89; write i_addr=7'h59, i_wdata=8'hA5 -> slave data_in=8'hA5; o_nack=0; o_data_nack=0; o_done 80 cycles after accept.
2. Read i_addr=7'h59, slave i_data_out=8'h3C -> o_rdata=8'h3C; o_nack=0; o_sdata=1 during k9..k19.
3. Write i_addr=7'h12, i_wdata=8'h00 -> o_nack=1; o_sdata=1 for k11..k19; a following write to 7'h59 with 8'h5A succeeds with slave data_in=8'h5A.
4. i_start pulsed at cycles 10 and 40 after the first accept -> second request ignored; exactly one o_done pulse; latched i_addr unchanged.
5. i_rst_n low at bit k5 -> o_sclk=0, o_sdata=1, o_busy=0 within the same cycle (async); no o_done pulse.
6. CLK_DIV=1, back-to-back read then write with i_start asserted in the cycle after o_done -> both complete with correct data; o_sclk period is 2 i_clk cycles.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte serial master: emits a fixed 20-bit frame (start, address, R/W, data)
// on o_sclk/o_sdata and samples ACKs and read data from the slave's return line.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_nack,
    output logic       o_data_nack,
    output logic       o_sclk,
    output logic       o_sdata,
    input  logic       i_sdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] K_LAST   = 5'd19;

    logic [1:0] state_r;
    logic [7:0] div_r;
    logic [4:0] k_r;
    logic       rw_r;
    logic [6:0] addr_r;
    logic [7:0] wdata_r;
    logic [2:0] rd_idx_s;

    // Read byte arrives MSB first on bits 11..18.
    assign rd_idx_s = 3'(5'd18 - k_r);

    // Outbound data bit for frame position k; after an address NACK the line is held high.
    function automatic logic bit_value(input logic [4:0] k, input logic rw,
                                       input logic [6:0] addr, input logic [7:0] wdata,
                                       input logic nack);
        logic       v;
        logic [2:0] a_idx;
        logic [2:0] w_idx;
        a_idx = 3'(5'd7 - k);
        w_idx = 3'(5'd17 - k);
        if (k == 5'd0) begin
            v = 1'b0;
        end else if (k <= 5'd7) begin
            v = addr[a_idx];
        end else if (k == 5'd8) begin
            v = rw;
        end else if ((k >= 5'd10) && (k <= 5'd17) && !rw && !nack) begin
            v = wdata[w_idx];
        end else begin
            v = 1'b1;
        end
        return v;
    endfunction

    // Frame sequencer: divider, bit counter, serial outputs and captured status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= S_IDLE;
            div_r       <= 8'd0;
            k_r         <= 5'd0;
            rw_r        <= 1'b0;
            addr_r      <= 7'd0;
            wdata_r     <= 8'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rdata     <= 8'd0;
            o_nack      <= 1'b0;
            o_data_nack <= 1'b0;
            o_sclk      <= 1'b0;
            o_sdata     <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        rw_r        <= i_rw;
                        addr_r      <= i_addr;
                        wdata_r     <= i_wdata;
                        o_nack      <= 1'b0;
                        o_data_nack <= 1'b0;
                        k_r         <= 5'd0;
                        div_r       <= 8'd0;
                        o_busy      <= 1'b1;
                        o_sdata     <= 1'b0;
                        state_r     <= S_LOW;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (div_r == DIV_LAST) begin
                        div_r   <= 8'd0;
                        o_sclk  <= 1'b1;
                        state_r <= S_HIGH;
                        // Sample before the slave reacts to this rising edge.
                        if (k_r == 5'd10) begin
                            o_nack <= i_sdata;
                        end else if ((k_r >= 5'd11) && (k_r <= 5'd18) && rw_r && !o_nack) begin
                            o_rdata[rd_idx_s] <= i_sdata;
                        end else if ((k_r == K_LAST) && !rw_r && i_sdata) begin
                            o_data_nack <= 1'b1;
                        end else begin
                            o_data_nack <= o_data_nack;
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_r == DIV_LAST) begin
                        div_r  <= 8'd0;
                        o_sclk <= 1'b0;
                        if (k_r == K_LAST) begin
                            o_sdata <= 1'b1;
                            o_done  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            k_r     <= k_r + 5'd1;
                            o_sdata <= bit_value(k_r + 5'd1, rw_r, addr_r, wdata_r, o_nack);
                            state_r <= S_LOW;
                        end
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    o_sclk  <= 1'b0;
                    o_sdata <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
